sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's basic FIFO (wr_en/rd_en/d_in/d_out/full/empty).
- Adds programmable almost-full and almost-empty thresholds, an occupancy count, and single-cycle overflow/underflow error pulses.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain. It is the DUT behind the existing driver/monitor clocking-block style bench.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- d_in  in  WIDTH  write data.
- d_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, sampled at posedge with rst=1:
  - wr_ptr, rd_ptr and count go to 0.
  - d_out=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Stored contents are discarded.
  - Reset overrides any wr_en/rd_en in the same cycle, including mid-burst.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. The address is the low bits, so wrap from DEPTH-1 to 0 is natural binary rollover.
- Accept rules, evaluated on registered flags at the posedge:
  - wr_acc = wr_en & (!full | rd_acc).
  - rd_acc = rd_en & !empty.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted. The read frees a slot, the write fills it, count stays DEPTH, full stays 1.
  - Empty: the write is accepted, the read is rejected (underflow pulse), and count becomes 1.
- count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Otherwise it holds.
  - count never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are registered. They are computed from the next count value, so they change in the same cycle that count changes.
- Standard mode (FWFT=0):
  - On rd_acc, d_out loads mem[rd_ptr] at that posedge, i.e. 1-cycle read latency.
  - d_out holds its value at all other times.
- FWFT mode (FWFT=1):
  - d_out presents the head entry whenever empty=0.
  - rd_acc pops the head, and the next entry (if any) appears on d_out after the same posedge.
  - A write into an empty FIFO is visible on d_out the cycle after the write (empty falls in that cycle).
  - d_out value while empty=1 is don't-care; the bench must not check it.
- Errors:
  - overflow = 1 for exactly the cycle after a posedge with wr_en & !wr_acc. Data is dropped and state is unchanged.
  - underflow = 1 for exactly the cycle after a posedge with rd_en & !rd_acc. d_out is unchanged.
  - Neither pulse is sticky.
- Elaboration: illegal parameters (DEPTH not a power of two, or thresholds out of range) trigger $fatal.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(depth) = $clog2(depth)+1;
  - the localparam-style defaults;
  - an enum fifo_mode_e {FIFO_STD, FIFO_FWFT} used to document the FWFT encoding.
- One sub-module, fifo_mem: DEPTH x WIDTH storage with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- The top holds the pointers, count, flags, error pulses and the d_out register/mux.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, d_out=0.
- Fill/drain (DEPTH=4, AF=3, AE=1, FWFT=0):
  - Write 0xA1..0xA4 on 4 consecutive cycles -> count 1,2,3,4; almost_full at count=3; full at 4.
  - Read 4 -> d_out 0xA1..0xA4, each one cycle after rd_en; empty=1 after the 4th.
- Overflow/underflow:
  - Write 0xEE when full -> overflow=1 for one cycle, count stays 4, and 0xEE is never read out.
  - Read when empty -> underflow=1 for one cycle, d_out unchanged.
- Simultaneous at boundaries:
  - Full with wr=rd=1 (d_in=0x55) -> count stays 4, oldest word popped, 0x55 read back last.
  - Empty with wr=rd=1 -> count=1, underflow=1.
- Wrap-around: 10 interleaved write/read pairs through DEPTH=4 with incrementing data -> in-order data, no flag glitches, and pointers cross the wrap bit twice.
- FWFT=1:
  - Write 0x11 into empty -> d_out=0x11 the next cycle with empty=0, before any rd_en.
  - Write 0x22, then rd_en -> d_out=0x22 immediately after that posedge.
  - Reset mid-burst -> empty=1 and count=0 on the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, pointer width helper and read-mode encoding
// for the sync_fifo_flags FIFO and its storage sub-module.
package fifo_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AE_LEVEL = 2;
    localparam int DEF_FWFT     = 0;

    // Read-mode encoding carried by the FWFT parameter.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address bits plus one wrap bit; also the occupancy count width.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, synchronous write port (we/waddr/wdata)
// and combinational read port (raddr -> rdata). Contents are not reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, error pulses
// and optional first-word-fall-through reads.
// Ports: clk, rst (sync, high), wr_en/d_in, rd_en/d_out, full, empty,
// almost_full, almost_empty, count, overflow, underflow.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = DEF_FWFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [WIDTH-1:0]          d_in,
    output logic [WIDTH-1:0]          d_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] ONE_C   = PW'(1);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
    localparam bit FWFT_MODE = (FWFT == int'(FIFO_FWFT));

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_flags: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_flags: AE_LEVEL out of range");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $fatal(1, "sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        // A pop in the same cycle frees the slot a full FIFO writes into.
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            if (!FWFT_MODE) begin
                dout_d = rdata;
            end
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = wr_en & ~wr_acc;
        udf_d   = rd_en & ~rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc & ~rst),
        .waddr(wr_ptr_q[AW-1:0]),
        .wdata(d_in),
        .raddr(rd_ptr_q[AW-1:0]),
        .rdata(rdata)
    );

    // Wrap bits only distinguish full from empty; count already does that.
    logic unused_wrap;
    assign unused_wrap = wr_ptr_q[PW-1] ^ rd_ptr_q[PW-1];

    // FWFT shows the head combinationally; forced to 0 while empty so
    // reset still presents d_out=0.
    assign d_out = FWFT_MODE ? (empty_q ? '0 : rdata) : dout_q;

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed bench for sync_fifo_flags, DEPTH=4,
// AF=3, AE=1, one standard-mode and one FWFT-mode instance.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst0, we0, re0;
    logic [7:0] din0, dout0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic [2:0] cnt0;
    logic       rst1, we1, re1;
    logic [7:0] din1, dout1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst0), .wr_en(we0), .rd_en(re0),
        .d_in(din0), .d_out(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst1), .wr_en(we1), .rd_en(re1),
        .d_in(din1), .d_out(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive the standard instance for one cycle.
    task automatic s0(input logic w, input logic r, input logic [7:0] d);
        we0 = w; re0 = r; din0 = d;
        cyc();
        we0 = 1'b0; re0 = 1'b0;
    endtask

    // Flag snapshot of the standard instance: {full,af,ae,empty}.
    function automatic logic [3:0] flg0();
        return {full0, af0, ae0, empty0};
    endfunction

    initial begin
        rst0 = 1'b1; we0 = 1'b0; re0 = 1'b0; din0 = '0;
        rst1 = 1'b1; we1 = 1'b0; re1 = 1'b0; din1 = '0;
        cyc();
        cyc();
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_flags", 32'(flg0()), 32'b0011);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_udf", 32'(udf0), 0);
        chk("rst_dout", 32'(dout0), 0);
        rst0 = 1'b0;
        s0(1'b0, 1'b0, 8'h00);
        chk("idle_count", 32'(cnt0), 0);
        chk("idle_flags", 32'(flg0()), 32'b0011);

        s0(1'b1, 1'b0, 8'hA1);
        chk("w1_count", 32'(cnt0), 1);
        chk("w1_flags", 32'(flg0()), 32'b0010);
        s0(1'b1, 1'b0, 8'hA2);
        chk("w2_count", 32'(cnt0), 2);
        chk("w2_flags", 32'(flg0()), 32'b0000);
        s0(1'b1, 1'b0, 8'hA3);
        chk("w3_count", 32'(cnt0), 3);
        chk("w3_flags", 32'(flg0()), 32'b0100);
        s0(1'b1, 1'b0, 8'hA4);
        chk("w4_count", 32'(cnt0), 4);
        chk("w4_flags", 32'(flg0()), 32'b1100);

        s0(1'b1, 1'b0, 8'hEE);
        chk("ovf_pulse", 32'(ovf0), 1);
        chk("ovf_count", 32'(cnt0), 4);
        s0(1'b0, 1'b0, 8'h00);
        chk("ovf_clear", 32'(ovf0), 0);

        s0(1'b0, 1'b1, 8'h00);
        chk("r1_dout", 32'(dout0), 32'hA1);
        chk("r1_count", 32'(cnt0), 3);
        chk("r1_flags", 32'(flg0()), 32'b0100);
        s0(1'b0, 1'b1, 8'h00);
        chk("r2_dout", 32'(dout0), 32'hA2);
        s0(1'b0, 1'b1, 8'h00);
        chk("r3_dout", 32'(dout0), 32'hA3);
        chk("r3_flags", 32'(flg0()), 32'b0010);
        s0(1'b0, 1'b1, 8'h00);
        chk("r4_dout", 32'(dout0), 32'hA4);
        chk("r4_count", 32'(cnt0), 0);
        chk("r4_flags", 32'(flg0()), 32'b0011);

        s0(1'b0, 1'b1, 8'h00);
        chk("udf_pulse", 32'(udf0), 1);
        chk("udf_dout", 32'(dout0), 32'hA4);
        chk("udf_count", 32'(cnt0), 0);
        s0(1'b0, 1'b0, 8'h00);
        chk("udf_clear", 32'(udf0), 0);

        s0(1'b1, 1'b0, 8'hB1);
        s0(1'b1, 1'b0, 8'hB2);
        s0(1'b1, 1'b0, 8'hB3);
        s0(1'b1, 1'b0, 8'hB4);
        chk("refill_full", 32'(full0), 1);
        s0(1'b1, 1'b1, 8'h55);
        chk("fwr_count", 32'(cnt0), 4);
        chk("fwr_full", 32'(full0), 1);
        chk("fwr_dout", 32'(dout0), 32'hB1);
        chk("fwr_ovf", 32'(ovf0), 0);
        s0(1'b0, 1'b1, 8'h00);
        chk("fd1_dout", 32'(dout0), 32'hB2);
        s0(1'b0, 1'b1, 8'h00);
        chk("fd2_dout", 32'(dout0), 32'hB3);
        s0(1'b0, 1'b1, 8'h00);
        chk("fd3_dout", 32'(dout0), 32'hB4);
        s0(1'b0, 1'b1, 8'h00);
        chk("fd4_dout", 32'(dout0), 32'h55);
        chk("fd4_empty", 32'(empty0), 1);

        s0(1'b1, 1'b1, 8'h66);
        chk("ewr_count", 32'(cnt0), 1);
        chk("ewr_udf", 32'(udf0), 1);
        chk("ewr_empty", 32'(empty0), 0);
        chk("ewr_dout", 32'(dout0), 32'h55);
        s0(1'b0, 1'b1, 8'h00);
        chk("ewr_rd", 32'(dout0), 32'h66);
        chk("ewr_rdc", 32'(cnt0), 0);

        for (int i = 0; i < 10; i++) begin
            s0(1'b1, 1'b0, 8'(8'hC0 + i));
            chk("wrap_wcnt", 32'(cnt0), 1);
            chk("wrap_wflg", 32'(flg0()), 32'b0010);
            s0(1'b0, 1'b1, 8'h00);
            chk("wrap_dout", 32'(dout0), 32'(8'hC0 + i));
            chk("wrap_rflg", 32'(flg0()), 32'b0011);
            chk("wrap_err", 32'({ovf0, udf0}), 0);
        end

        rst1 = 1'b0;
        cyc();
        chk("f_rst_empty", 32'(empty1), 1);
        we1 = 1'b1; din1 = 8'h11;
        cyc();
        we1 = 1'b0;
        chk("f_w1_empty", 32'(empty1), 0);
        chk("f_w1_dout", 32'(dout1), 32'h11);
        we1 = 1'b1; din1 = 8'h22;
        cyc();
        we1 = 1'b0;
        chk("f_w2_dout", 32'(dout1), 32'h11);
        chk("f_w2_count", 32'(cnt1), 2);
        re1 = 1'b1;
        cyc();
        re1 = 1'b0;
        chk("f_r1_dout", 32'(dout1), 32'h22);
        chk("f_r1_count", 32'(cnt1), 1);
        we1 = 1'b1; din1 = 8'h33;
        cyc();
        din1 = 8'h44;
        rst1 = 1'b1;
        cyc();
        chk("f_mrst_empty", 32'(empty1), 1);
        chk("f_mrst_count", 32'(cnt1), 0);
        chk("f_mrst_err", 32'({ovf1, udf1}), 0);
        rst1 = 1'b0; we1 = 1'b0;
        cyc();
        chk("f_post_empty", 32'(empty1), 1);
        chk("f_post_count", 32'(cnt1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
